timer_counter: RTL

//  64-bit up-counter with prescaler and debug-halt handshake; downstream consumer of register_file.

---
 rtl/timer_counter_if.sv | 32 +++
 rtl/timer_counter.sv | 69 ++++++
 2 files changed

// File: rtl/timer_counter_if.sv
// Control, load and status signals between the TCR/TDR/THCSR register file and the 64-bit timer.
// The master drives the control and load signals; the timer (slave) returns the count and the status.
interface timer_counter_if #(
    parameter int CNT_W = 64,
    parameter int DIV_W = 4
);
    logic             timer_en;
    logic             div_en;
    logic [DIV_W-1:0] div_val;
    logic             timer_en_H_L;
    logic             tdr0_wr_sel;
    logic             tdr1_wr_sel;
    logic [31:0]      tdr0;
    logic [31:0]      tdr1;
    logic             dbg_mode;
    logic             halt_req;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_tick;
    logic             halt_ack;

    modport master (
        output timer_en, div_en, div_val, timer_en_H_L, tdr0_wr_sel, tdr1_wr_sel,
               tdr0, tdr1, dbg_mode, halt_req,
        input  cnt_value, cnt_tick, halt_ack
    );

    modport slave (
        input  timer_en, div_en, div_val, timer_en_H_L, tdr0_wr_sel, tdr1_wr_sel,
               tdr0, tdr1, dbg_mode, halt_req,
        output cnt_value, cnt_tick, halt_ack
    );
endinterface

// File: rtl/timer_counter.sv
// 64-bit up-counter with a power-of-two prescaler, delayed TDR half-loads and a debug-halt handshake.
module timer_counter #(
    parameter int CNT_W   = 64,
    parameter int DIV_W   = 4,
    parameter int DIV_MAX = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    timer_counter_if.slave bus
);
    logic       wr0_d, wr1_d;
    logic [7:0] p;
    logic [3:0] eff_div;
    logic [7:0] p_term;
    logic       undiv, load, tick;

    // Out-of-range exponents are clamped so the prescaler never exceeds 2^DIV_MAX.
    always_comb begin
        eff_div = 4'(bus.div_val);
        if (bus.div_val > DIV_W'(DIV_MAX)) eff_div = 4'(DIV_MAX);
    end

    assign p_term = 8'((9'd1 << eff_div) - 9'd1);
    assign undiv  = !bus.div_en || (eff_div == 4'd0);
    assign load   = wr0_d || wr1_d;
    assign tick   = bus.timer_en && !bus.halt_ack && (undiv || (p == p_term));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr0_d        <= 1'b0;
            wr1_d        <= 1'b0;
            bus.halt_ack <= 1'b0;
        end else begin
            wr0_d        <= bus.tdr0_wr_sel;
            wr1_d        <= bus.tdr1_wr_sel;
            bus.halt_ack <= bus.halt_req && bus.dbg_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= 8'd0;
        end else if (!bus.timer_en || bus.timer_en_H_L || load) begin
            p <= 8'd0;
        end else if (!bus.halt_ack) begin
            if (undiv || (p == p_term)) p <= 8'd0;
            else                        p <= p + 8'd1;
        end
    end

    // Clear beats load beats increment; only the increment branch raises cnt_tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cnt_value <= '0;
            bus.cnt_tick  <= 1'b0;
        end else begin
            bus.cnt_tick <= 1'b0;
            if (bus.timer_en_H_L) begin
                bus.cnt_value <= '0;
            end else if (load) begin
                if (wr0_d) bus.cnt_value[31:0]  <= bus.tdr0;
                if (wr1_d) bus.cnt_value[63:32] <= bus.tdr1;
            end else if (tick) begin
                bus.cnt_value <= bus.cnt_value + 64'd1;
                bus.cnt_tick  <= 1'b1;
            end
        end
    end
endmodule
